axi_lite_rr_arbiter: RTL and testbench
======================================

// Module: axi_lite_rr_arbiter
// PURPOSE
//  N-master to 1-slave AXI4-Lite arbiter for the interconnect. Read and write paths are arbitrated independently.
//  Each grant covers exactly one full transaction: AW+W+B for writes, AR+R for reads.
//  Round-robin priority. Upstream ports face masters/drivers; the downstream port faces a single slave.
// PARAMETERS
//  N_MASTERS   2    number of upstream masters (2..4)
//  ADDR_WIDTH  12   address width (matches the package)
//  DATA_WIDTH  8    data width; STRB_WIDTH = DATA_WIDTH/8
// PORTS
//  ACLK                  in   1            clock; all logic on rising edge
//  ARESETn               in   1            synchronous, active-low reset
//  m_awaddr/m_araddr     in   N*ADDR_WIDTH packed; master i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH]
//  m_awvalid/m_arvalid   in   N            per-master address valid
//  m_awready/m_arready   out  N            per-master address ready
//  m_wdata/m_wstrb       in   N*DATA_WIDTH / N*STRB_WIDTH   packed write data/strobe
//  m_wvalid in N; m_wready out N           write data handshake
//  m_bresp out N*2; m_bvalid out N; m_bready in N        write response
//  m_rdata out N*DATA_WIDTH; m_rresp out N*2; m_rvalid out N; m_rready in N   read data
//  s_aw*/s_w*/s_b*/s_ar*/s_r*              single-master AXI4-Lite bus toward the slave (directions mirrored)
//  wr_grant/rd_grant     out  N            one-hot current owner; 0 when idle
// BEHAVIOUR
//  Reset: every output valid/ready, both grants and all muxed data outputs are 0.
//   Both FSMs go to IDLE. Both RR pointers = 0, so master 0 ranks first.
//  Write FSM:
//   WR_IDLE: if any m_awvalid, pick the first requester at or after wr_ptr (cyclic).
//    Register wr_grant, then go to WR_ADDR. Grant latency = 1 cycle: s_awvalid earliest one cycle after m_awvalid.
//   WR_ADDR: pass the granted master's AW and W channels to s_aw/s_w; s_awready/s_wready route back to that master only.
//    Track aw_done and w_done separately; AW and W may complete in either order or in the same cycle.
//    After each handshake, drop that channel's valid to the slave.
//    When both are done, go to WR_RESP.
//   WR_RESP: route s_b to the granted master; s_bready = m_bready[g].
//    On s_bvalid & s_bready: return to WR_IDLE, clear wr_grant, set wr_ptr = (g+1) mod N.
//  Read FSM (RD_IDLE -> RD_ADDR -> RD_DATA), same rules:
//   AR handshake moves to RD_DATA.
//   R handshake returns to RD_IDLE and sets rd_ptr = (g+1) mod N.
//  Non-granted masters: every ready and valid toward them is 0, and their requests stay pending with no timeout.
//  A master's W arriving before its AW is granted is held off (m_wready = 0).
//  Read and write may be granted to the same or different masters in the same cycle.
//  Back-to-back: the earliest regrant is the cycle after the B/R handshake. Minimum of 1 idle cycle per transaction per path.
//  Granted master drops valid before handshake (protocol violation): the arbiter keeps the grant and waits; no recovery logic.
//  Reset during a transaction: abandon it immediately; outputs return to their reset values on the next edge.
//  Slave response is passed through unchanged, including SLVERR and DECERR.
// CONFIGURATION
//  AXIL_ARB_FIXED_PRIO_EN defined: fixed priority (lowest index wins).
//   wr_ptr/rd_ptr are never updated; they stay 0.
//  Not defined: round-robin as described above (default).
// TESTING
//  1. Single write: M0 writes addr 0x004, data 0xA5, strb 1.
//     -> s_awaddr = 0x004 one cycle after request, wr_grant = 01, M0 gets bresp OKAY, grant returns to 00.
//  2. Contention: M0 and M1 both request write in the same cycle (0x004 / 0x014), 4 rounds.
//     -> grants alternate M0, M1, M0, M1.
//     -> with AXIL_ARB_FIXED_PRIO_EN: M0 always first; M1 served only while M0 is idle.
//  3. W-before-AW and AW/W in the same cycle at the slave
//     -> both orders reach WR_RESP exactly once; no duplicate s_awvalid.
//  4. Concurrent paths: M0 write to 0x014 while M1 reads 0x004
//     -> both granted in the same cycle; rdata of 0x004 is returned to M1 only.
//  5. Backpressure: slave holds bvalid 5 cycles; M0 holds bready low 3 cycles
//     -> no grant change until the B handshake; M1's pending AW is not readied.
//  6. ARESETn low mid-WR_ADDR
//     -> all valids/readies 0 at the next edge, grants 0, pointers 0; a fresh transaction afterwards completes OKAY.

Source files
------------

// File: rtl/axi_lite_rr_arbiter.sv
// N-master to 1-slave AXI4-Lite arbiter, independent write/read round-robin owners, one transaction per grant.
// Define AXIL_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module axi_lite_rr_arbiter #(
    parameter int N_MASTERS  = 2,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
) (
    input  logic                                  ACLK,
    input  logic                                  ARESETn,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0]       m_awaddr,
    input  logic [N_MASTERS-1:0]                  m_awvalid,
    output logic [N_MASTERS-1:0]                  m_awready,
    input  logic [N_MASTERS*DATA_WIDTH-1:0]       m_wdata,
    input  logic [N_MASTERS*(DATA_WIDTH/8)-1:0]   m_wstrb,
    input  logic [N_MASTERS-1:0]                  m_wvalid,
    output logic [N_MASTERS-1:0]                  m_wready,
    output logic [N_MASTERS*2-1:0]                m_bresp,
    output logic [N_MASTERS-1:0]                  m_bvalid,
    input  logic [N_MASTERS-1:0]                  m_bready,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0]       m_araddr,
    input  logic [N_MASTERS-1:0]                  m_arvalid,
    output logic [N_MASTERS-1:0]                  m_arready,
    output logic [N_MASTERS*DATA_WIDTH-1:0]       m_rdata,
    output logic [N_MASTERS*2-1:0]                m_rresp,
    output logic [N_MASTERS-1:0]                  m_rvalid,
    input  logic [N_MASTERS-1:0]                  m_rready,
    output logic [ADDR_WIDTH-1:0]                 s_awaddr,
    output logic                                  s_awvalid,
    input  logic                                  s_awready,
    output logic [DATA_WIDTH-1:0]                 s_wdata,
    output logic [(DATA_WIDTH/8)-1:0]             s_wstrb,
    output logic                                  s_wvalid,
    input  logic                                  s_wready,
    input  logic [1:0]                            s_bresp,
    input  logic                                  s_bvalid,
    output logic                                  s_bready,
    output logic [ADDR_WIDTH-1:0]                 s_araddr,
    output logic                                  s_arvalid,
    input  logic                                  s_arready,
    input  logic [DATA_WIDTH-1:0]                 s_rdata,
    input  logic [1:0]                            s_rresp,
    input  logic                                  s_rvalid,
    output logic                                  s_rready,
    output logic [N_MASTERS-1:0]                  wr_grant,
    output logic [N_MASTERS-1:0]                  rd_grant
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_W      = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_ADDR = 2'd1,
        WR_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_ADDR = 2'd1,
        RD_DATA = 2'd2
    } rd_state_t;

    // First requester at or after ptr, scanning cyclically.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_MASTERS-1:0] req,
                                                 input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] sel;
        logic             found;
        int               idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < N_MASTERS; k++) begin
            idx = (int'(ptr) + k) % N_MASTERS;
            if (!found && req[idx[IDX_W-1:0]]) begin
                sel   = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        if (int'(idx) == N_MASTERS - 1) begin
            return '0;
        end else begin
            return idx + 1'b1;
        end
    endfunction

    function automatic logic [N_MASTERS-1:0] to_onehot(input logic [IDX_W-1:0] idx);
        logic [N_MASTERS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    wr_state_t        wr_state_r, wr_state_s;
    logic [IDX_W-1:0] wr_idx_r, wr_ptr_r, wr_pick_s;
    logic             aw_done_r, w_done_r;
    logic             aw_hs_s, w_hs_s, b_hs_s;

    rd_state_t        rd_state_r, rd_state_s;
    logic [IDX_W-1:0] rd_idx_r, rd_ptr_r, rd_pick_s;
    logic             ar_hs_s, r_hs_s;

    // Write path: next state, handshake detection and channel routing to the owner.
    always_comb begin
        wr_state_s = wr_state_r;
        wr_pick_s  = rr_pick(m_awvalid, wr_ptr_r);
        aw_hs_s    = 1'b0;
        w_hs_s     = 1'b0;
        b_hs_s     = 1'b0;
        s_awaddr   = '0;
        s_awvalid  = 1'b0;
        s_wdata    = '0;
        s_wstrb    = '0;
        s_wvalid   = 1'b0;
        s_bready   = 1'b0;
        m_awready  = '0;
        m_wready   = '0;
        m_bresp    = '0;
        m_bvalid   = '0;
        case (wr_state_r)
            WR_IDLE: begin
                if (|m_awvalid) begin
                    wr_state_s = WR_ADDR;
                end else begin
                    wr_state_s = WR_IDLE;
                end
            end
            WR_ADDR: begin
                s_awaddr            = m_awaddr[wr_idx_r*ADDR_WIDTH +: ADDR_WIDTH];
                s_wdata             = m_wdata[wr_idx_r*DATA_WIDTH +: DATA_WIDTH];
                s_wstrb             = m_wstrb[wr_idx_r*STRB_WIDTH +: STRB_WIDTH];
                // Each channel is presented only until its own handshake completes.
                s_awvalid           = !aw_done_r && m_awvalid[wr_idx_r];
                s_wvalid            = !w_done_r && m_wvalid[wr_idx_r];
                m_awready[wr_idx_r] = !aw_done_r && s_awready;
                m_wready[wr_idx_r]  = !w_done_r && s_wready;
                aw_hs_s             = s_awvalid && s_awready;
                w_hs_s              = s_wvalid && s_wready;
                if ((aw_done_r || aw_hs_s) && (w_done_r || w_hs_s)) begin
                    wr_state_s = WR_RESP;
                end else begin
                    wr_state_s = WR_ADDR;
                end
            end
            WR_RESP: begin
                s_bready                 = m_bready[wr_idx_r];
                m_bvalid[wr_idx_r]       = s_bvalid;
                m_bresp[wr_idx_r*2 +: 2] = s_bresp;
                b_hs_s                   = s_bvalid && s_bready;
                if (b_hs_s) begin
                    wr_state_s = WR_IDLE;
                end else begin
                    wr_state_s = WR_RESP;
                end
            end
            default: begin
                wr_state_s = WR_IDLE;
            end
        endcase
    end

    // Write path state, owner, grant, per-channel completion and priority pointer.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            wr_state_r <= WR_IDLE;
            wr_idx_r   <= '0;
            wr_ptr_r   <= '0;
            wr_grant   <= '0;
            aw_done_r  <= 1'b0;
            w_done_r   <= 1'b0;
        end else begin
            wr_state_r <= wr_state_s;
            case (wr_state_r)
                WR_IDLE: begin
                    if (|m_awvalid) begin
                        wr_idx_r  <= wr_pick_s;
                        wr_grant  <= to_onehot(wr_pick_s);
                        aw_done_r <= 1'b0;
                        w_done_r  <= 1'b0;
                    end
                end
                WR_ADDR: begin
                    if (aw_hs_s) begin
                        aw_done_r <= 1'b1;
                    end
                    if (w_hs_s) begin
                        w_done_r <= 1'b1;
                    end
                end
                WR_RESP: begin
                    if (b_hs_s) begin
                        wr_grant <= '0;
`ifdef AXIL_ARB_FIXED_PRIO_EN
                        wr_ptr_r <= '0;
`else
                        wr_ptr_r <= next_idx(wr_idx_r);
`endif
                    end
                end
                default: begin
                    wr_grant <= '0;
                end
            endcase
        end
    end

    // Read path: next state, handshake detection and channel routing to the owner.
    always_comb begin
        rd_state_s = rd_state_r;
        rd_pick_s  = rr_pick(m_arvalid, rd_ptr_r);
        ar_hs_s    = 1'b0;
        r_hs_s     = 1'b0;
        s_araddr   = '0;
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;
        m_arready  = '0;
        m_rdata    = '0;
        m_rresp    = '0;
        m_rvalid   = '0;
        case (rd_state_r)
            RD_IDLE: begin
                if (|m_arvalid) begin
                    rd_state_s = RD_ADDR;
                end else begin
                    rd_state_s = RD_IDLE;
                end
            end
            RD_ADDR: begin
                s_araddr            = m_araddr[rd_idx_r*ADDR_WIDTH +: ADDR_WIDTH];
                s_arvalid           = m_arvalid[rd_idx_r];
                m_arready[rd_idx_r] = s_arready;
                ar_hs_s             = s_arvalid && s_arready;
                if (ar_hs_s) begin
                    rd_state_s = RD_DATA;
                end else begin
                    rd_state_s = RD_ADDR;
                end
            end
            RD_DATA: begin
                s_rready                                = m_rready[rd_idx_r];
                m_rvalid[rd_idx_r]                      = s_rvalid;
                m_rdata[rd_idx_r*DATA_WIDTH +: DATA_WIDTH] = s_rdata;
                m_rresp[rd_idx_r*2 +: 2]                = s_rresp;
                r_hs_s                                  = s_rvalid && s_rready;
                if (r_hs_s) begin
                    rd_state_s = RD_IDLE;
                end else begin
                    rd_state_s = RD_DATA;
                end
            end
            default: begin
                rd_state_s = RD_IDLE;
            end
        endcase
    end

    // Read path state, owner, grant and priority pointer.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            rd_state_r <= RD_IDLE;
            rd_idx_r   <= '0;
            rd_ptr_r   <= '0;
            rd_grant   <= '0;
        end else begin
            rd_state_r <= rd_state_s;
            case (rd_state_r)
                RD_IDLE: begin
                    if (|m_arvalid) begin
                        rd_idx_r <= rd_pick_s;
                        rd_grant <= to_onehot(rd_pick_s);
                    end
                end
                RD_ADDR: begin
                    rd_grant <= rd_grant;
                end
                RD_DATA: begin
                    if (r_hs_s) begin
                        rd_grant <= '0;
`ifdef AXIL_ARB_FIXED_PRIO_EN
                        rd_ptr_r <= '0;
`else
                        rd_ptr_r <= next_idx(rd_idx_r);
`endif
                    end
                end
                default: begin
                    rd_grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_rr_arbiter.sv
// Randomized bench for axi_lite_rr_arbiter: random master/slave traffic checked each cycle
// against a transaction-level owner/pointer model, with one reset injected mid-write.
module tb_axi_lite_rr_arbiter;

    localparam int N  = 3;
    localparam int AW = 12;
    localparam int DW = 8;
    localparam int SW = 1;
    localparam int N_CYCLES = 4000;

    logic              ACLK;
    logic              ARESETn;
    logic [N*AW-1:0]   m_awaddr, m_araddr;
    logic [N-1:0]      m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [N-1:0]      m_arvalid, m_arready, m_rvalid, m_rready;
    logic [N*DW-1:0]   m_wdata, m_rdata;
    logic [N*SW-1:0]   m_wstrb;
    logic [N*2-1:0]    m_bresp, m_rresp;
    logic [AW-1:0]     s_awaddr, s_araddr;
    logic              s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic              s_arvalid, s_arready, s_rvalid, s_rready;
    logic [DW-1:0]     s_wdata, s_rdata;
    logic [SW-1:0]     s_wstrb;
    logic [1:0]        s_bresp, s_rresp;
    logic [N-1:0]      wr_grant, rd_grant;

    axi_lite_rr_arbiter #(.N_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .wr_grant(wr_grant), .rd_grant(rd_grant)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Master-side stimulus state
    logic [AW-1:0] wa[N], ra[N];
    logic [DW-1:0] wd[N];
    logic [SW-1:0] ws[N];
    int            wdly[N];
    logic [N-1:0]  w_act, awv, wv, w_sent, brdy, r_act, arv, rrdy;
    // Slave-side stimulus state
    logic          s_awr, s_wr, s_bv, s_arr, s_rv;
    // Reference model: current owner (-1 idle), priority pointer, transaction progress
    int            wo, wptr, ro, rptr;
    logic          aw_seen, w_seen, ar_seen;

    function automatic int pick(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (req[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic int after(input int g);
`ifdef AXIL_ARB_FIXED_PRIO_EN
        return 0;
`else
        return (g + 1) % N;
`endif
    endfunction

    task automatic clear_all();
        w_act = '0; awv = '0; wv = '0; w_sent = '0; brdy = '0;
        r_act = '0; arv = '0; rrdy = '0;
        s_awr = 1'b0; s_wr = 1'b0; s_bv = 1'b0; s_arr = 1'b0; s_rv = 1'b0;
        for (int i = 0; i < N; i++) begin
            wa[i] = '0; ra[i] = '0; wd[i] = '0; ws[i] = '0; wdly[i] = 0;
        end
    endtask

    task automatic model_reset();
        wo = -1; wptr = 0; ro = -1; rptr = 0;
        aw_seen = 1'b0; w_seen = 1'b0; ar_seen = 1'b0;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            m_awaddr[i*AW +: AW] = wa[i];
            m_araddr[i*AW +: AW] = ra[i];
            m_wdata[i*DW +: DW]  = wd[i];
            m_wstrb[i*SW +: SW]  = ws[i];
        end
        m_awvalid = awv; m_wvalid = wv; m_bready = brdy;
        m_arvalid = arv; m_rready = rrdy;
        s_awready = s_awr; s_wready = s_wr; s_arready = s_arr;
        s_bvalid  = s_bv;
        s_bresp   = (s_bv && wo >= 0) ? wa[wo][5:4] : 2'b00;
        s_rvalid  = s_rv;
        s_rdata   = (s_rv && ro >= 0) ? (ra[ro][7:0] ^ 8'h5A) : 8'h00;
        s_rresp   = (s_rv && ro >= 0) ? ra[ro][9:8] : 2'b00;
    endtask

    task automatic step_stim();
        for (int i = 0; i < N; i++) begin
            if (!w_act[i] && $urandom_range(0, 3) == 0) begin
                w_act[i] = 1'b1; awv[i] = 1'b1; w_sent[i] = 1'b0;
                wa[i] = AW'($urandom); wd[i] = DW'($urandom); ws[i] = SW'($urandom);
                wdly[i] = int'($urandom_range(0, 2));
            end
            if (w_act[i] && !w_sent[i] && !wv[i]) begin
                if (wdly[i] == 0) wv[i] = 1'b1;
                else wdly[i]--;
            end
            brdy[i] = ($urandom_range(0, 2) != 0);
            if (!r_act[i] && $urandom_range(0, 3) == 0) begin
                r_act[i] = 1'b1; arv[i] = 1'b1; ra[i] = AW'($urandom);
            end
            rrdy[i] = ($urandom_range(0, 2) != 0);
        end
        s_awr = ($urandom_range(0, 2) != 0);
        s_wr  = ($urandom_range(0, 2) != 0);
        s_arr = ($urandom_range(0, 2) != 0);
        if (!s_bv && wo >= 0 && aw_seen && w_seen && $urandom_range(0, 1) == 0) s_bv = 1'b1;
        if (!s_rv && ro >= 0 && ar_seen && $urandom_range(0, 1) == 0) s_rv = 1'b1;
    endtask

    task automatic check_cycle();
        logic [N-1:0]    e_gnt, e_awr, e_wr, e_bv, e_rgnt, e_arr, e_rv;
        logic            e_awv, e_wv, e_br, e_arv, e_rr;
        logic [2*N-1:0]  e_bresp, e_rresp;
        logic [DW*N-1:0] e_rdata;
        e_gnt = '0; e_awr = '0; e_wr = '0; e_bv = '0; e_awv = 1'b0; e_wv = 1'b0; e_br = 1'b0;
        e_rgnt = '0; e_arr = '0; e_rv = '0; e_arv = 1'b0; e_rr = 1'b0;
        e_bresp = '0; e_rresp = '0; e_rdata = '0;
        if (wo >= 0) begin
            e_gnt[wo] = 1'b1;
            if (!(aw_seen && w_seen)) begin
                e_awv     = !aw_seen && awv[wo];
                e_wv      = !w_seen && wv[wo];
                e_awr[wo] = !aw_seen && s_awr;
                e_wr[wo]  = !w_seen && s_wr;
            end else begin
                e_bv[wo] = s_bv;
                e_br     = brdy[wo];
            end
        end
        check_eq("wr_grant", wr_grant, e_gnt);
        check_eq("s_awvalid", s_awvalid, e_awv);
        check_eq("s_wvalid", s_wvalid, e_wv);
        check_eq("m_awready", m_awready, e_awr);
        check_eq("m_wready", m_wready, e_wr);
        check_eq("m_bvalid", m_bvalid, e_bv);
        check_eq("s_bready", s_bready, e_br);
        if (e_awv) check_eq("s_awaddr", s_awaddr, wa[wo]);
        if (e_wv) check_eq("s_wdata_strb", {s_wdata, s_wstrb}, {wd[wo], ws[wo]});
        if (wo >= 0 && aw_seen && w_seen && s_bv) begin
            e_bresp[wo*2 +: 2] = wa[wo][5:4];
            check_eq("m_bresp", m_bresp, e_bresp);
        end

        if (ro >= 0) begin
            e_rgnt[ro] = 1'b1;
            if (!ar_seen) begin
                e_arv     = arv[ro];
                e_arr[ro] = s_arr;
            end else begin
                e_rv[ro] = s_rv;
                e_rr     = rrdy[ro];
            end
        end
        check_eq("rd_grant", rd_grant, e_rgnt);
        check_eq("s_arvalid", s_arvalid, e_arv);
        check_eq("m_arready", m_arready, e_arr);
        check_eq("m_rvalid", m_rvalid, e_rv);
        check_eq("s_rready", s_rready, e_rr);
        if (e_arv) check_eq("s_araddr", s_araddr, ra[ro]);
        if (ro >= 0 && ar_seen && s_rv) begin
            e_rdata[ro*DW +: DW] = ra[ro][7:0] ^ 8'h5A;
            e_rresp[ro*2 +: 2]   = ra[ro][9:8];
            check_eq("m_rdata", m_rdata, e_rdata);
            check_eq("m_rresp", m_rresp, e_rresp);
        end
    endtask

    // Advance model and stimulus state to reflect the coming rising edge.
    task automatic update_model();
        if (!ARESETn) begin
            model_reset();
            s_bv = 1'b0;
            s_rv = 1'b0;
            return;
        end
        if (wo < 0) begin
            if (awv != '0) begin
                wo = pick(awv, wptr); aw_seen = 1'b0; w_seen = 1'b0;
            end
        end else if (!(aw_seen && w_seen)) begin
            if (!aw_seen && awv[wo] && s_awr) begin
                aw_seen = 1'b1; awv[wo] = 1'b0;
            end
            if (!w_seen && wv[wo] && s_wr) begin
                w_seen = 1'b1; wv[wo] = 1'b0; w_sent[wo] = 1'b1;
            end
        end else if (s_bv && brdy[wo]) begin
            w_act[wo] = 1'b0; s_bv = 1'b0; wptr = after(wo); wo = -1;
        end
        if (ro < 0) begin
            if (arv != '0) begin
                ro = pick(arv, rptr); ar_seen = 1'b0;
            end
        end else if (!ar_seen) begin
            if (arv[ro] && s_arr) begin
                ar_seen = 1'b1; arv[ro] = 1'b0;
            end
        end else if (s_rv && rrdy[ro]) begin
            r_act[ro] = 1'b0; s_rv = 1'b0; rptr = after(ro); ro = -1;
        end
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_ctrl"}, {wr_grant, rd_grant, m_awready, m_wready, m_bvalid, m_arready,
                  m_rvalid, s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready}, 64'd0);
        check_eq({tag, "_sdata"}, {s_awaddr, s_wdata, s_wstrb, s_araddr}, 64'd0);
        check_eq({tag, "_mdata"}, {m_bresp, m_rdata, m_rresp}, 64'd0);
    endtask

    initial begin
        logic rst_done, rst_chk, chk_now;
        rst_done = 1'b0;
        rst_chk  = 1'b0;
        ARESETn  = 1'b0;
        clear_all();
        model_reset();
        drive();
        repeat (3) @(negedge ACLK);
        #1;
        check_quiet("reset");

        for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
            @(negedge ACLK);
            chk_now = rst_chk;
            rst_chk = 1'b0;
            if (!rst_done && cyc >= N_CYCLES / 2 && wo >= 0 && !(aw_seen && w_seen)) begin
                ARESETn  = 1'b0;
                clear_all();
                rst_done = 1'b1;
                rst_chk  = 1'b1;
            end else begin
                ARESETn = 1'b1;
                step_stim();
            end
            drive();
            #1;
            if (chk_now) check_quiet("post_reset");
            check_cycle();
            update_model();
        end
        check_eq("mid_write_reset_applied", rst_done, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
